// File: rtl/dnoc_itf_core_wr_mb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dnoc_itf_core_wr_mb : core output stream -> local L2 (multi-buffer, strided)
//                       or -> NoC as a single burst.
// Revision: 1.0
// ---------------------------------------------------------------------------
module dnoc_itf_core_wr_mb #(
  parameter int DW        = 256,
  parameter int AW        = 13,
  parameter int LW        = 13,
  parameter int NBUF      = 4,
  parameter int MAX_OUTST = 8,
  parameter int FW        = 11,
  localparam int BW       = $clog2(NBUF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_req,
  output logic               cmd_gnt,
  input  logic [NBUF*AW-1:0] cfg_base_addr,
  input  logic [NBUF*LW-1:0] cfg_len,
  input  logic [AW-1:0]      cfg_stride,
  input  logic [BW-1:0]      cfg_buf_last,
  input  logic [FW-1:0]      cfg_fill_last,
  input  logic               cfg_local,
  input  logic [NBUF-1:0]    buf_busy,
  output logic [NBUF-1:0]    buf_wr_done,
  output logic               transaction_done,
  output logic               err_unexp_resp,
  input  logic [DW-1:0]      core_out_data,
  input  logic               core_out_valid,
  output logic               core_out_ready,
  output logic               noc_out_req,
  input  logic               noc_out_gnt,
  output logic [DW-1:0]      noc_out_data,
  output logic               noc_out_valid,
  output logic               noc_out_last,
  input  logic               noc_out_ready,
  input  logic               noc_in_wr_response,
  output logic               l2_wr_req,
  input  logic               l2_wr_gnt,
  output logic [AW-1:0]      l2_wr_addr,
  output logic [DW-1:0]      l2_wr_data,
  input  logic               l2_wr_resp
);

  localparam int            OW          = $clog2(MAX_OUTST + 1);
  localparam logic [OW-1:0] C_MAX_OUTST = OW'(MAX_OUTST);

  typedef enum logic [2:0] {
    S_IDLE, S_NOC_REQ, S_NOC_WR, S_NOC_RESP, S_BUF_WAIT, S_BUF_WR, S_BUF_DRAIN
  } state_t;

  state_t        r_state;
  logic [BW-1:0] r_buf_idx;
  logic [FW-1:0] r_fill_cnt;
  logic [LW:0]   r_req_cnt;
  logic [LW:0]   r_resp_cnt;
  logic [LW-1:0] r_beat_cnt;
  logic [OW-1:0] r_outst;
  logic [AW-1:0] r_addr;
  logic          r_err;

  logic [LW-1:0] w_len;
  logic [LW:0]   w_len_ext;
  logic [LW:0]   w_len_p1;
  logic [LW:0]   w_resp_next;
  logic [AW-1:0] w_base;
  logic          w_acc;
  logic          w_resp_ok;
  logic          w_resp_cnt;
  logic          w_allow;
  logic          w_buf_gnt;
  logic          w_drain_done;
  logic          w_last_fill;
  logic          w_noc_beat;

  assign w_len       = cfg_len[r_buf_idx*LW +: LW];
  assign w_base      = cfg_base_addr[r_buf_idx*AW +: AW];
  assign w_len_ext   = {1'b0, w_len};
  assign w_len_p1    = w_len_ext + (LW+1)'(1);
  assign w_acc       = l2_wr_req & l2_wr_gnt;
  // Responses with nothing outstanding are not counted anywhere; they only flag an error.
  assign w_resp_ok   = l2_wr_resp & (r_outst != '0);
  assign w_resp_cnt  = w_resp_ok & ((r_state == S_BUF_WR) | (r_state == S_BUF_DRAIN));
  assign w_resp_next = r_resp_cnt + {{LW{1'b0}}, w_resp_cnt};
  assign w_allow     = (r_req_cnt <= w_len_ext) & (r_outst < C_MAX_OUTST);
  assign w_buf_gnt   = (r_state == S_BUF_WAIT) & cmd_req & ~buf_busy[r_buf_idx];
  assign w_drain_done = (r_state == S_BUF_DRAIN) & (w_resp_next >= w_len_p1);
  assign w_last_fill = (r_fill_cnt == cfg_fill_last);
  assign w_noc_beat  = (r_state == S_NOC_WR) & core_out_valid & noc_out_ready;

  assign cmd_gnt          = ((r_state == S_NOC_REQ) & noc_out_gnt) | w_buf_gnt;
  assign noc_out_req      = (r_state == S_NOC_REQ);
  assign noc_out_valid    = (r_state == S_NOC_WR) & core_out_valid;
  assign noc_out_last     = noc_out_valid & (r_beat_cnt == cfg_len[LW-1:0]);
  assign noc_out_data     = core_out_data;
  assign l2_wr_data       = core_out_data;
  assign l2_wr_req        = (r_state == S_BUF_WR) & core_out_valid & w_allow;
  assign core_out_ready   = (r_state == S_NOC_WR) ? noc_out_ready : w_acc;
  assign l2_wr_addr       = r_addr;
  assign err_unexp_resp   = r_err;
  assign buf_wr_done      = w_drain_done ? (NBUF'(1) << r_buf_idx) : '0;
  assign transaction_done = ((r_state == S_NOC_RESP) & noc_in_wr_response) |
                            (w_drain_done & w_last_fill);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_buf_idx  <= '0;
      r_fill_cnt <= '0;
      r_req_cnt  <= '0;
      r_resp_cnt <= '0;
      r_beat_cnt <= '0;
      r_outst    <= '0;
      r_addr     <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_acc & ~w_resp_ok) begin
        r_outst <= r_outst + OW'(1);
      end else if (~w_acc & w_resp_ok) begin
        r_outst <= r_outst - OW'(1);
      end
      if (w_resp_cnt) begin
        r_resp_cnt <= w_resp_next;
      end

      case (r_state)
        S_IDLE: begin
          if (cmd_req) begin
            if (cfg_local) begin
              r_state    <= S_BUF_WAIT;
              r_buf_idx  <= '0;
              r_fill_cnt <= '0;
              r_err      <= 1'b0;
            end else begin
              r_state <= S_NOC_REQ;
            end
          end
        end
        S_NOC_REQ: begin
          if (noc_out_gnt) begin
            r_state    <= S_NOC_WR;
            r_beat_cnt <= '0;
          end
        end
        S_NOC_WR: begin
          if (w_noc_beat) begin
            if (r_beat_cnt == cfg_len[LW-1:0]) begin
              r_state <= S_NOC_RESP;
            end else begin
              r_beat_cnt <= r_beat_cnt + LW'(1);
            end
          end
        end
        S_NOC_RESP: begin
          if (noc_in_wr_response) begin
            r_state <= S_IDLE;
          end
        end
        S_BUF_WAIT: begin
          if (w_buf_gnt) begin
            r_state    <= S_BUF_WR;
            r_req_cnt  <= '0;
            r_resp_cnt <= '0;
            r_addr     <= w_base;
          end
        end
        S_BUF_WR: begin
          if (w_acc) begin
            r_addr    <= r_addr + cfg_stride;
            r_req_cnt <= r_req_cnt + (LW+1)'(1);
            if (r_req_cnt == w_len_ext) begin
              r_state <= S_BUF_DRAIN;
            end
          end
        end
        S_BUF_DRAIN: begin
          if (w_drain_done) begin
            r_buf_idx <= (r_buf_idx == cfg_buf_last) ? '0 : r_buf_idx + BW'(1);
            if (w_last_fill) begin
              r_state <= S_IDLE;
            end else begin
              r_fill_cnt <= r_fill_cnt + FW'(1);
              r_state    <= S_BUF_WAIT;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Placed last so a spurious response wins over the clear on a new local command.
      if (l2_wr_resp & (r_outst == '0)) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dnoc_itf_core_wr_mb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dnoc_itf_core_wr_mb : directed bench, table-driven single fills plus
//                          hand-written NoC, multi-buffer, limit, error and reset sequences.
// ---------------------------------------------------------------------------
module tb_dnoc_itf_core_wr_mb;
  localparam int DW = 256, AW = 13, LW = 13, NBUF = 4, MAX_OUTST = 2, FW = 11, BW = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cmd_req = 1'b0;
  logic               cmd_gnt;
  logic [NBUF*AW-1:0] cfg_base_addr = '0;
  logic [NBUF*LW-1:0] cfg_len = '0;
  logic [AW-1:0]      cfg_stride = '0;
  logic [BW-1:0]      cfg_buf_last = '0;
  logic [FW-1:0]      cfg_fill_last = '0;
  logic               cfg_local = 1'b0;
  logic [NBUF-1:0]    buf_busy = '0;
  logic [NBUF-1:0]    buf_wr_done;
  logic               transaction_done, err_unexp_resp;
  logic [DW-1:0]      core_out_data = '0;
  logic               core_out_valid = 1'b0;
  logic               core_out_ready;
  logic               noc_out_req;
  logic               noc_out_gnt = 1'b0;
  logic [DW-1:0]      noc_out_data;
  logic               noc_out_valid, noc_out_last;
  logic               noc_out_ready = 1'b0;
  logic               noc_in_wr_response = 1'b0;
  logic               l2_wr_req;
  logic               l2_wr_gnt = 1'b1;
  logic [AW-1:0]      l2_wr_addr;
  logic [DW-1:0]      l2_wr_data;
  logic               l2_wr_resp;
  logic               auto_resp = 1'b0, spur_resp = 1'b0;

  assign l2_wr_resp = auto_resp | spur_resp;

  dnoc_itf_core_wr_mb #(
    .DW(DW), .AW(AW), .LW(LW), .NBUF(NBUF), .MAX_OUTST(MAX_OUTST), .FW(FW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_req(cmd_req), .cmd_gnt(cmd_gnt),
    .cfg_base_addr(cfg_base_addr), .cfg_len(cfg_len), .cfg_stride(cfg_stride),
    .cfg_buf_last(cfg_buf_last), .cfg_fill_last(cfg_fill_last), .cfg_local(cfg_local),
    .buf_busy(buf_busy), .buf_wr_done(buf_wr_done), .transaction_done(transaction_done),
    .err_unexp_resp(err_unexp_resp), .core_out_data(core_out_data),
    .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
    .noc_out_req(noc_out_req), .noc_out_gnt(noc_out_gnt), .noc_out_data(noc_out_data),
    .noc_out_valid(noc_out_valid), .noc_out_last(noc_out_last), .noc_out_ready(noc_out_ready),
    .noc_in_wr_response(noc_in_wr_response), .l2_wr_req(l2_wr_req), .l2_wr_gnt(l2_wr_gnt),
    .l2_wr_addr(l2_wr_addr), .l2_wr_data(l2_wr_data), .l2_wr_resp(l2_wr_resp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0;
  int resp_dly = 1;
  int due_q[$];
  int m_outst = 0;
  logic [AW-1:0] addr_q[$];
  int acc_cyc_q[$];
  int done_q[$];
  int td_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // L2 responder: one write response resp_dly cycles after each accepted request
  always @(posedge clk) begin
    #1;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      auto_resp = 1'b1;
      void'(due_q.pop_front());
    end else begin
      auto_resp = 1'b0;
    end
  end

  // Monitor: bench-side outstanding model, address/done logging
  always @(negedge clk) begin
    if (!rst_n) begin
      m_outst = 0;
    end else begin
      if (l2_wr_req) chk("req_below_max_outst", 32'(m_outst < MAX_OUTST), 32'd1);
      if (l2_wr_req && l2_wr_gnt) begin
        addr_q.push_back(l2_wr_addr);
        acc_cyc_q.push_back(cyc);
        due_q.push_back(cyc + resp_dly);
      end
      m_outst = m_outst + ((l2_wr_req && l2_wr_gnt) ? 1 : 0) - ((l2_wr_resp && m_outst > 0) ? 1 : 0);
      for (int b = 0; b < NBUF; b++) if (buf_wr_done[b]) done_q.push_back(b);
      if (transaction_done) td_cnt++;
    end
  end

  task automatic clear_logs();
    addr_q.delete();
    acc_cyc_q.delete();
    done_q.delete();
    td_cnt = 0;
  endtask

  task automatic set_local(input logic [BW-1:0] blast, input logic [FW-1:0] flast,
                           input logic [AW-1:0] stride);
    cfg_local     = 1'b1;
    cfg_buf_last  = blast;
    cfg_fill_last = flast;
    cfg_stride    = stride;
  endtask

  // Hold cmd_req/valid until transaction_done, then drop them before the DUT returns to IDLE
  task automatic run_local(input int budget, output bit ok);
    ok = 1'b0;
    cmd_req = 1'b1;
    core_out_valid = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (transaction_done) begin
        ok = 1'b1;
        break;
      end
    end
    cmd_req = 1'b0;
    core_out_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_gnt"}, 32'(cmd_gnt), 32'd0);
    chk({tag, "_core_ready"}, 32'(core_out_ready), 32'd0);
    chk({tag, "_noc_ctl"}, {29'd0, noc_out_req, noc_out_valid, noc_out_last}, 32'd0);
    chk({tag, "_l2_req"}, 32'(l2_wr_req), 32'd0);
    chk({tag, "_l2_addr"}, 32'(l2_wr_addr), 32'd0);
    chk({tag, "_done"}, {27'd0, buf_wr_done, transaction_done}, 32'd0);
    chk({tag, "_err"}, 32'(err_unexp_resp), 32'd0);
    chk({tag, "_noc_data"}, noc_out_data[31:0], core_out_data[31:0]);
    chk({tag, "_l2_data"}, l2_wr_data[31:0], core_out_data[31:0]);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] stride;
    logic [LW-1:0] len;
    int            beats;
    logic [AW-1:0] first;
    logic [AW-1:0] last;
  } vec_t;

  vec_t vecs[5];

  initial begin
    bit ok;
    int beat;
    bit tog;
    bit gnt_seen;

    vecs[0] = '{base: 13'h0100, stride: 13'h0004, len: 13'd0, beats: 1, first: 13'h0100, last: 13'h0100};
    vecs[1] = '{base: 13'h0010, stride: 13'h0020, len: 13'd2, beats: 3, first: 13'h0010, last: 13'h0050};
    vecs[2] = '{base: 13'h1F00, stride: 13'h0080, len: 13'd3, beats: 4, first: 13'h1F00, last: 13'h0080};
    vecs[3] = '{base: 13'h0000, stride: 13'h1FFF, len: 13'd2, beats: 3, first: 13'h0000, last: 13'h1FFE};
    vecs[4] = '{base: 13'h0AAA, stride: 13'h0000, len: 13'd4, beats: 5, first: 13'h0AAA, last: 13'h0AAA};

    // ---------------- reset state ----------------
    core_out_data  = {8{32'h5A5A_0F0F}};
    core_out_valid = 1'b1;
    cmd_req        = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk_all_zero("rst");
    core_out_valid = 1'b0;
    cmd_req        = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---------------- NoC burst, len=3, ready toggling ----------------
    cfg_local = 1'b0;
    cfg_len[LW-1:0] = 13'd3;
    cmd_req = 1'b1;
    @(negedge clk);
    chk("noc_idle_no_req", 32'(noc_out_req), 32'd0);
    @(negedge clk);
    chk("noc_req_asserted", 32'(noc_out_req), 32'd1);
    chk("noc_no_gnt_yet", 32'(cmd_gnt), 32'd0);
    @(posedge clk); #1;
    noc_out_gnt = 1'b1;
    @(negedge clk);
    chk("noc_cmd_gnt", 32'(cmd_gnt), 32'd1);
    @(posedge clk); #1;
    cmd_req = 1'b0;
    noc_out_gnt = 1'b0;
    beat = 0;
    tog = 1'b0;
    for (int i = 0; i < 40 && beat < 4; i++) begin
      noc_out_ready  = tog;
      tog            = ~tog;
      core_out_valid = 1'b1;
      core_out_data  = DW'(32'hA0 + beat);
      @(negedge clk);
      chk("noc_valid_pass", 32'(noc_out_valid), 32'd1);
      chk("noc_ready_pass", 32'(core_out_ready), 32'(noc_out_ready));
      chk("noc_last", 32'(noc_out_last), 32'(beat == 3));
      if (noc_out_valid && noc_out_ready) begin
        chk("noc_data", noc_out_data[31:0], 32'hA0 + 32'(beat));
        beat++;
      end
      @(posedge clk); #1;
    end
    chk("noc_beats", 32'(beat), 32'd4);
    noc_out_ready = 1'b1;
    @(negedge clk);
    chk("noc_resp_wait_ctl", {29'd0, noc_out_valid, core_out_ready, transaction_done}, 32'd0);
    @(posedge clk); #1;
    noc_in_wr_response = 1'b1;
    @(negedge clk);
    chk("noc_td_on_resp", 32'(transaction_done), 32'd1);
    @(posedge clk); #1;
    noc_in_wr_response = 1'b0;
    core_out_valid = 1'b0;
    noc_out_ready = 1'b0;
    @(negedge clk);
    chk("noc_back_idle", {30'd0, transaction_done, noc_out_req}, 32'd0);
    @(posedge clk); #1;

    // ---------------- table: single local fills ----------------
    resp_dly = 1;
    foreach (vecs[v]) begin
      set_local(2'd0, 11'd0, vecs[v].stride);
      cfg_base_addr[AW-1:0] = vecs[v].base;
      cfg_len[LW-1:0]       = vecs[v].len;
      clear_logs();
      run_local(200, ok);
      chk($sformatf("v%0d_timeout", v), 32'(ok), 32'd1);
      chk($sformatf("v%0d_beats", v), 32'(addr_q.size()), 32'(vecs[v].beats));
      if (addr_q.size() > 0) begin
        chk($sformatf("v%0d_first_addr", v), 32'(addr_q[0]), 32'(vecs[v].first));
        chk($sformatf("v%0d_last_addr", v), 32'(addr_q[addr_q.size()-1]), 32'(vecs[v].last));
        chk($sformatf("v%0d_back_to_back", v),
            32'(acc_cyc_q[acc_cyc_q.size()-1] - acc_cyc_q[0]), 32'(vecs[v].beats - 1));
      end
      chk($sformatf("v%0d_done_cnt", v), 32'(done_q.size()), 32'd1);
      if (done_q.size() > 0) chk($sformatf("v%0d_done_idx", v), 32'(done_q[0]), 32'd0);
      chk($sformatf("v%0d_td_cnt", v), 32'(td_cnt), 32'd1);
    end

    // ---------------- address wrap: base 0x1FFE, stride 1, len 3 ----------------
    set_local(2'd0, 11'd0, 13'd1);
    cfg_base_addr[AW-1:0] = 13'h1FFE;
    cfg_len[LW-1:0]       = 13'd3;
    clear_logs();
    run_local(100, ok);
    chk("wrap_timeout", 32'(ok), 32'd1);
    chk("wrap_cnt", 32'(addr_q.size()), 32'd4);
    if (addr_q.size() == 4) begin
      chk("wrap_a0", 32'(addr_q[0]), 32'h1FFE);
      chk("wrap_a1", 32'(addr_q[1]), 32'h1FFF);
      chk("wrap_a2", 32'(addr_q[2]), 32'h0000);
      chk("wrap_a3", 32'(addr_q[3]), 32'h0001);
    end

    // ---------------- buffer rotation: buf_last=2, fill_last=5 ----------------
    set_local(2'd2, 11'd5, 13'd1);
    for (int s = 0; s < NBUF; s++) begin
      cfg_base_addr[s*AW +: AW] = AW'(s * 'h100);
      cfg_len[s*LW +: LW]       = 13'd1;
    end
    clear_logs();
    run_local(400, ok);
    chk("rot_timeout", 32'(ok), 32'd1);
    chk("rot_done_cnt", 32'(done_q.size()), 32'd6);
    for (int k = 0; k < done_q.size() && k < 6; k++)
      chk($sformatf("rot_done_%0d", k), 32'(done_q[k]), 32'(k % 3));
    chk("rot_td_cnt", 32'(td_cnt), 32'd1);
    chk("rot_addr_cnt", 32'(addr_q.size()), 32'd12);
    if (addr_q.size() == 12) begin
      chk("rot_fill1_addr", 32'(addr_q[2]), 32'h0100);
      chk("rot_fill2_addr", 32'(addr_q[5]), 32'h0201);
      chk("rot_fill3_addr", 32'(addr_q[6]), 32'h0000);
    end

    // ---------------- outstanding limit: MAX_OUTST=2, response delay 5 ----------------
    resp_dly = 5;
    set_local(2'd0, 11'd0, 13'd1);
    cfg_base_addr[AW-1:0] = 13'h0000;
    cfg_len[LW-1:0]       = 13'd7;
    clear_logs();
    run_local(300, ok);
    chk("outst_timeout", 32'(ok), 32'd1);
    chk("outst_beats", 32'(addr_q.size()), 32'd8);
    if (acc_cyc_q.size() >= 3) begin
      chk("outst_pair_gap", 32'(acc_cyc_q[1] - acc_cyc_q[0]), 32'd1);
      chk("outst_stall_gap", 32'(acc_cyc_q[2] - acc_cyc_q[0]), 32'd6);
    end
    resp_dly = 1;

    // ---------------- consumer hold: buf_busy[1] for 20 cycles ----------------
    set_local(2'd1, 11'd1, 13'd1);
    buf_busy = 4'b0010;
    clear_logs();
    cmd_req = 1'b1;
    core_out_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (|buf_wr_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("busy_fill0_done", 32'(ok), 32'd1);
    gnt_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      gnt_seen |= cmd_gnt;
    end
    chk("busy_gnt_withheld", 32'(gnt_seen), 32'd0);
    @(posedge clk); #1;
    buf_busy = 4'b0000;
    @(negedge clk);
    chk("busy_gnt_on_release", 32'(cmd_gnt), 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (transaction_done) begin
        ok = 1'b1;
        break;
      end
    end
    cmd_req = 1'b0;
    core_out_valid = 1'b0;
    @(posedge clk); #1;
    chk("busy_td", 32'(ok), 32'd1);
    chk("busy_done_cnt", 32'(done_q.size()), 32'd2);
    if (done_q.size() == 2) chk("busy_done_seq", 32'(done_q[1]), 32'd1);

    // ---------------- spurious L2 response in IDLE ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("spur_err_before", 32'(err_unexp_resp), 32'd0);
    spur_resp = 1'b1;
    @(posedge clk); #1;
    spur_resp = 1'b0;
    @(negedge clk);
    chk("spur_err_set", 32'(err_unexp_resp), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("spur_err_sticky", 32'(err_unexp_resp), 32'd1);
    set_local(2'd0, 11'd0, 13'd1);
    cfg_len[LW-1:0] = 13'd0;
    @(posedge clk); #1;
    cmd_req = 1'b1;
    core_out_valid = 1'b1;
    @(negedge clk);
    chk("spur_err_in_idle", 32'(err_unexp_resp), 32'd1);
    chk("spur_no_gnt_idle", 32'(cmd_gnt), 32'd0);
    @(negedge clk);
    chk("spur_err_cleared", 32'(err_unexp_resp), 32'd0);
    chk("spur_gnt_next", 32'(cmd_gnt), 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (transaction_done) begin
        ok = 1'b1;
        break;
      end
    end
    cmd_req = 1'b0;
    core_out_valid = 1'b0;
    @(posedge clk); #1;
    chk("spur_td", 32'(ok), 32'd1);

    // ---------------- async reset during BUF_WR ----------------
    resp_dly = 5;
    cfg_len[LW-1:0] = 13'd7;
    clear_logs();
    cmd_req = 1'b1;
    core_out_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (addr_q.size() >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rstmid_reached_wr", 32'(ok), 32'd1);
    #2;
    rst_n = 1'b0;
    cmd_req = 1'b0;
    #1;
    chk_all_zero("rstmid");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (due_q.size() == 0 && !auto_resp) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
    chk("rstmid_resp_drained", 32'(ok), 32'd1);
    chk("rstmid_late_resp_err", 32'(err_unexp_resp), 32'd1);
    chk("rstmid_idle", {29'd0, l2_wr_req, core_out_ready, noc_out_req}, 32'd0);
    core_out_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
`default_nettype wire
